demux_1xn_rr: RTL and testbench

Parametrised 1-to-N word demultiplexer for the PCIe byte-striping datapath. It spreads an incoming valid-qualified stream across `LANES` output lanes, either round-robin or by explicit lane select. Each lane has a one-entry output register with a ready/valid handshake, so downstream backpressure stalls the source instead of dropping data. It replaces cascaded 1x2 demux trees with a single block of any power-of-two width.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_lane_reg.sv | 33 +++
 rtl/demux_1xn_rr.sv | 87 ++++++++
 tb/tb_demux_1xn_rr.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-N word demultiplexer.
package demux_pkg;

  // Lane steering modes.
  localparam int DEMUX_RR  = 32'sd0;
  localparam int DEMUX_SEL = 32'sd1;

  // Width of a lane index for a given lane count (never narrower than 1 bit).
  function automatic int lane_idx_width(input int lanes);
    if (lanes > 32'sd1) begin
      return $clog2(lanes);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output register for a single demux lane with ready/valid handshake.
module demux_lane_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  // The lane can take a word when it is empty or is being drained this cycle.
  assign free = !out_valid | out_ready;

  // Lane state: a load wins over a drain, so back-to-back words keep valid high.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/demux_1xn_rr.sv
// 1-to-LANES word demultiplexer: round-robin or explicit lane select, with a
// one-entry handshake register per lane so backpressure stalls the source.
module demux_1xn_rr
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int MODE  = DEMUX_RR
) (
  input  logic                                 clk,
  input  logic                                 reset_L,
  input  logic [WIDTH-1:0]                     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [lane_idx_width(LANES)-1:0]     in_sel,
  input  logic                                 realign,
  output logic [LANES*WIDTH-1:0]               out_data,
  output logic [LANES-1:0]                     out_valid,
  input  logic [LANES-1:0]                     out_ready,
  output logic [lane_idx_width(LANES)-1:0]     ptr
);

  localparam int SW = lane_idx_width(LANES);
  localparam logic [SW-1:0] PTR_ZERO = SW'(0);
  localparam logic [SW-1:0] PTR_ONE  = SW'(1);

  logic [SW-1:0]    ptr_r;
  logic [SW-1:0]    tgt_s;
  logic [LANES-1:0] free_s;
  logic [LANES-1:0] load_s;
  logic             acc_s;

  // Target lane: the round-robin pointer, or the caller's select in SEL mode.
  always_comb begin
    tgt_s = ptr_r;
    if (MODE == DEMUX_SEL) begin
      tgt_s = in_sel;
    end else begin
      tgt_s = ptr_r;
    end
  end

  // Only the target lane's state gates the input; a stalled target blocks
  // even when other lanes are free, so the pointer never skips a lane.
  assign in_ready = free_s[tgt_s];
  assign acc_s    = in_valid & in_ready;
  assign ptr      = ptr_r;

  // One-hot load decode of the accepted word onto its target lane.
  always_comb begin
    load_s = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      load_s[k] = acc_s & (tgt_s == SW'(k));
    end
  end

  // Round-robin pointer: realign beats the increment; held at 0 in SEL mode.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_r <= PTR_ZERO;
    end else if (MODE == DEMUX_SEL) begin
      ptr_r <= PTR_ZERO;
    end else if (realign) begin
      ptr_r <= PTR_ZERO;
    end else if (acc_s) begin
      ptr_r <= ptr_r + PTR_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset_L   (reset_L),
      .load      (load_s[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[k*WIDTH +: WIDTH]),
      .free      (free_s[k])
    );
  end

endmodule

// File: tb/tb_demux_1xn_rr.sv
// Directed bench for demux_1xn_rr: RR and SEL instances (8-bit, 4 lanes) plus
// an RR 16-bit 8-lane instance driven with random valid/ready and a scoreboard.
module tb_demux_1xn_rr;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // RR instance
  logic [7:0]  rr_in_data = 8'h00;
  logic        rr_in_valid = 1'b0, rr_in_ready, rr_realign = 1'b0;
  logic [1:0]  rr_in_sel = 2'd0, rr_ptr;
  logic [31:0] rr_out_data;
  logic [3:0]  rr_out_valid, rr_out_ready = 4'hF;

  // SEL instance
  logic [7:0]  sel_in_data = 8'h00;
  logic        sel_in_valid = 1'b0, sel_in_ready, sel_realign = 1'b0;
  logic [1:0]  sel_in_sel = 2'd0, sel_ptr;
  logic [31:0] sel_out_data;
  logic [3:0]  sel_out_valid, sel_out_ready = 4'hF;

  // Wide instance
  logic [15:0]  big_in_data = 16'h0000;
  logic         big_in_valid = 1'b0, big_in_ready;
  logic [2:0]   big_in_sel = 3'd0, big_ptr;
  logic [127:0] big_out_data;
  logic [7:0]   big_out_valid, big_out_ready = 8'h00;

  demux_1xn_rr #(.WIDTH(8), .LANES(4), .MODE(DEMUX_RR)) u_rr (
    .clk(clk), .reset_L(reset_L), .in_data(rr_in_data), .in_valid(rr_in_valid),
    .in_ready(rr_in_ready), .in_sel(rr_in_sel), .realign(rr_realign),
    .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(rr_out_ready), .ptr(rr_ptr));

  demux_1xn_rr #(.WIDTH(8), .LANES(4), .MODE(DEMUX_SEL)) u_sel (
    .clk(clk), .reset_L(reset_L), .in_data(sel_in_data), .in_valid(sel_in_valid),
    .in_ready(sel_in_ready), .in_sel(sel_in_sel), .realign(sel_realign),
    .out_data(sel_out_data), .out_valid(sel_out_valid), .out_ready(sel_out_ready), .ptr(sel_ptr));

  demux_1xn_rr #(.WIDTH(16), .LANES(8), .MODE(DEMUX_RR)) u_big (
    .clk(clk), .reset_L(reset_L), .in_data(big_in_data), .in_valid(big_in_valid),
    .in_ready(big_in_ready), .in_sel(big_in_sel), .realign(1'b0),
    .out_data(big_out_data), .out_valid(big_out_valid), .out_ready(big_out_ready), .ptr(big_ptr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rr_lane(input int k);
    return rr_out_data[k*8 +: 8];
  endfunction

  function automatic logic [7:0] sel_lane(input int k);
    return sel_out_data[k*8 +: 8];
  endfunction

  function automatic logic [15:0] big_lane(input int k);
    return big_out_data[k*16 +: 16];
  endfunction

  logic [15:0] m_data [8];
  logic [7:0]  m_valid;
  logic [2:0]  m_ptr;
  logic        m_acc;

  initial begin
    // ---------------- reset state (asserted, before any edge)
    #3;
    chk("rst_valid", 64'(rr_out_valid), 64'h0);
    chk("rst_ptr", 64'(rr_ptr), 64'h0);
    chk("rst_ready", 64'(rr_in_ready), 64'h1);
    #9 reset_L = 1'b1;
    step();

    // ---------------- RR streaming 0x10..0x17, all lanes ready
    for (int i = 0; i < 8; i++) begin
      rr_in_valid = 1'b1;
      rr_in_data  = 8'(8'h10 + i);
      #1;
      chk("stream_in_ready", 64'(rr_in_ready), 64'h1);
      step();
      chk("stream_lane_data", 64'(rr_lane(i % 4)), 64'(8'h10 + i));
      chk("stream_lane_valid", 64'(rr_out_valid[i % 4]), 64'h1);
      chk("stream_ptr", 64'(rr_ptr), 64'((i + 1) % 4));
    end
    rr_in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(rr_out_valid), 64'h0);

    // ---------------- backpressure on lane 2
    rr_out_ready = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      rr_in_valid = 1'b1;
      rr_in_data  = 8'(8'hA0 + i);
      step();
    end
    rr_in_valid = 1'b0;
    step();
    chk("bp_valid_mask", 64'(rr_out_valid), 64'h4);
    chk("bp_lane2_data", 64'(rr_lane(2)), 64'hA2);
    chk("bp_ptr", 64'(rr_ptr), 64'h0);
    for (int i = 0; i < 2; i++) begin
      rr_in_valid = 1'b1;
      rr_in_data  = 8'(8'hB0 + i);
      #1;
      chk("bp_b_ready", 64'(rr_in_ready), 64'h1);
      step();
      chk("bp_b_data", 64'(rr_lane(i)), 64'(8'hB0 + i));
    end
    rr_in_data = 8'hB2;
    #1;
    chk("bp_stall_ready", 64'(rr_in_ready), 64'h0);
    step();
    chk("bp_stall_ptr", 64'(rr_ptr), 64'h2);
    chk("bp_stall_hold", 64'(rr_lane(2)), 64'hA2);
    chk("bp_stall_valid", 64'(rr_out_valid[2]), 64'h1);
    rr_out_ready = 4'hF;
    #1;
    chk("bp_release_ready", 64'(rr_in_ready), 64'h1);
    step();
    chk("bp_release_data", 64'(rr_lane(2)), 64'hB2);
    chk("bp_release_valid", 64'(rr_out_valid), 64'h4);
    chk("bp_release_ptr", 64'(rr_ptr), 64'h3);
    rr_in_data = 8'hB3;
    step();
    chk("bp_b3_data", 64'(rr_lane(3)), 64'hB3);
    chk("bp_b3_ptr", 64'(rr_ptr), 64'h0);
    rr_in_valid = 1'b0;
    step();
    chk("bp_drained", 64'(rr_out_valid), 64'h0);

    // ---------------- realign
    rr_in_valid = 1'b1;
    rr_in_data  = 8'h30;
    step();
    rr_in_data  = 8'h31;
    step();
    chk("ra_setup_ptr", 64'(rr_ptr), 64'h2);
    rr_in_data = 8'h55;
    rr_realign = 1'b1;
    step();
    rr_realign = 1'b0;
    chk("ra_lane2_data", 64'(rr_lane(2)), 64'h55);
    chk("ra_lane2_valid", 64'(rr_out_valid[2]), 64'h1);
    chk("ra_ptr", 64'(rr_ptr), 64'h0);
    rr_in_data = 8'h56;
    step();
    chk("ra_next_lane0", 64'(rr_lane(0)), 64'h56);
    chk("ra_next_ptr", 64'(rr_ptr), 64'h1);
    rr_in_valid = 1'b0;
    rr_realign  = 1'b1;
    step();
    rr_realign = 1'b0;
    chk("ra_idle_ptr", 64'(rr_ptr), 64'h0);

    // ---------------- async reset mid-stream with lanes 1 and 2 full
    rr_out_ready = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      rr_in_valid = 1'b1;
      rr_in_data  = 8'(8'h60 + i);
      step();
    end
    rr_in_valid = 1'b0;
    step();
    chk("ar_pre_valid", 64'(rr_out_valid), 64'h6);
    chk("ar_pre_ptr", 64'(rr_ptr), 64'h3);
    #2 reset_L = 1'b0;
    #1;
    chk("ar_valid", 64'(rr_out_valid), 64'h0);
    chk("ar_data", 64'(rr_out_data), 64'h0);
    chk("ar_ptr", 64'(rr_ptr), 64'h0);
    chk("ar_ready", 64'(rr_in_ready), 64'h1);
    #2 reset_L = 1'b1;
    rr_out_ready = 4'hF;
    step();
    chk("ar_after_valid", 64'(rr_out_valid), 64'h0);

    // ---------------- SEL mode
    sel_out_ready = 4'b0111;
    sel_in_valid  = 1'b1;
    sel_in_sel    = 2'd3;
    sel_in_data   = 8'h01;
    sel_realign   = 1'b1;
    step();
    sel_realign = 1'b0;
    chk("sel_lane3_first", 64'(sel_lane(3)), 64'h01);
    chk("sel_valid_first", 64'(sel_out_valid), 64'h8);
    chk("sel_ptr", 64'(sel_ptr), 64'h0);
    sel_in_data = 8'h02;
    #1;
    chk("sel_stall_ready", 64'(sel_in_ready), 64'h0);
    step();
    chk("sel_stall_hold", 64'(sel_lane(3)), 64'h01);
    sel_out_ready = 4'hF;
    #1;
    chk("sel_release_ready", 64'(sel_in_ready), 64'h1);
    step();
    chk("sel_lane3_second", 64'(sel_lane(3)), 64'h02);
    sel_in_sel  = 2'd0;
    sel_in_data = 8'h03;
    step();
    chk("sel_lane0", 64'(sel_lane(0)), 64'h03);
    chk("sel_valid_last", 64'(sel_out_valid), 64'h1);
    chk("sel_ptr_last", 64'(sel_ptr), 64'h0);
    sel_in_valid = 1'b0;
    step();

    // ---------------- 16-bit, 8-lane random valid/ready with scoreboard
    m_valid = 8'h00;
    m_ptr   = 3'd0;
    for (int k = 0; k < 8; k++) m_data[k] = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      big_in_valid  = 1'($urandom_range(0, 1));
      big_in_data   = 16'($urandom);
      big_out_ready = 8'($urandom);
      #1;
      chk("big_valid", 64'(big_out_valid), 64'(m_valid));
      chk("big_ptr", 64'(big_ptr), 64'(m_ptr));
      m_acc = big_in_valid & (!m_valid[m_ptr] | big_out_ready[m_ptr]);
      chk("big_ready", 64'(big_in_ready), 64'(!m_valid[m_ptr] | big_out_ready[m_ptr]));
      for (int k = 0; k < 8; k++) begin
        if (m_valid[k] && big_out_ready[k]) begin
          chk("big_drain_data", 64'(big_lane(k)), 64'(m_data[k]));
          m_valid[k] = 1'b0;
        end
      end
      if (m_acc) begin
        m_data[m_ptr]  = big_in_data;
        m_valid[m_ptr] = 1'b1;
        m_ptr          = m_ptr + 3'd1;
      end
      step();
    end
    big_in_valid = 1'b0;
    big_out_ready = 8'hFF;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (m_valid[k]) chk("big_tail_data", 64'(big_lane(k)), 64'(m_data[k]));
    end
    step();
    chk("big_final_empty", 64'(big_out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
